// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
//
// Converts single-cycle request pulses, each carrying a data word, into a
// registered high level held for HOLD_CYCLES cycles. Every high level is
// followed by a low gap of at least GAP_CYCLES cycles, so a one-shot consumer
// that re-arms on the falling level fires exactly once per accepted pulse.
// A one-entry pending buffer queues a pulse that arrives while a level is
// being produced. A pulse that finds the buffer full is dropped and raises
// the sticky overrun flag.
//
// Parameters:
//   DW          width of the captured data word
//   HOLD_CYCLES cycles o_level stays high per accepted pulse (>= 1)
//   GAP_CYCLES  minimum low cycles between two stretched pulses (>= 1)
//   RETRIGGER   1: a pulse during HOLD reloads the hold time and data
//               0: a pulse during HOLD is queued in the pending buffer
//
// Ports:
//   i_clk      clock, all state changes on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_en       block enable; low forces IDLE and drops the pending entry
//   i_pulse    request pulse, sampled every cycle
//   i_data     data word captured with i_pulse
//   i_ack      early release of the current HOLD
//   i_ovr_clr  clears o_overrun
//   o_level    stretched level (registered)
//   o_data     data of the current or last stretched pulse
//   o_busy     high while not IDLE or while the pending entry is valid
//   o_overrun  sticky: a pulse was dropped
// -----------------------------------------------------------------------------
module pulse_stretch #(
  parameter int DW          = 32,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 1,
  parameter int RETRIGGER   = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_pulse,
  input  logic [DW-1:0] i_data,
  input  logic          i_ack,
  input  logic          i_ovr_clr,
  output logic          o_level,
  output logic [DW-1:0] o_data,
  output logic          o_busy,
  output logic          o_overrun
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  // Counters count down to zero, so a load of N-1 gives exactly N cycles.
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state,    state_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [GW-1:0]   gap_cnt,  gap_nxt;
  logic            pend_v,   pend_v_nxt;
  logic [DW-1:0]   pend_d,   pend_d_nxt;
  logic [DW-1:0]   data_nxt;
  logic            ovr_nxt;
  logic            queue_pulse;  // this cycle's pulse must go to pending
  logic            drop;         // pulse met a full pending entry

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    gap_nxt     = gap_cnt;
    pend_v_nxt  = pend_v;
    pend_d_nxt  = pend_d;
    data_nxt    = o_data;
    ovr_nxt     = o_overrun;
    queue_pulse = 1'b0;
    drop        = 1'b0;

    if (!i_en) begin
      // Disable overrides everything: o_data and o_overrun are kept.
      state_nxt  = IDLE;
      pend_v_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_pulse) begin
            data_nxt  = i_data;
            hold_nxt  = HOLD_LOAD;
            state_nxt = HOLD;
          end
        end

        HOLD: begin
          if (i_ack) begin
            state_nxt   = GAP;
            gap_nxt     = GAP_LOAD;
            queue_pulse = i_pulse;
          end else if ((RETRIGGER != 0) && i_pulse) begin
            // Retrigger extends the level seamlessly, with no gap.
            hold_nxt = HOLD_LOAD;
            data_nxt = i_data;
          end else if (hold_cnt == '0) begin
            state_nxt   = GAP;
            gap_nxt     = GAP_LOAD;
            queue_pulse = i_pulse;
          end else begin
            hold_nxt    = hold_cnt - HW'(1);
            queue_pulse = i_pulse;
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            if (pend_v) begin
              // The queued pulse is served; a pulse arriving now finds the
              // entry still occupied and is dropped.
              data_nxt   = pend_d;
              pend_v_nxt = 1'b0;
              drop       = i_pulse;
              hold_nxt   = HOLD_LOAD;
              state_nxt  = HOLD;
            end else if (i_pulse) begin
              // Pulse passes through the empty pending entry straight out.
              data_nxt  = i_data;
              hold_nxt  = HOLD_LOAD;
              state_nxt = HOLD;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            gap_nxt     = gap_cnt - GW'(1);
            queue_pulse = i_pulse;
          end
        end

        default: state_nxt = IDLE;
      endcase

      if (queue_pulse) begin
        if (pend_v) begin
          drop = 1'b1;  // oldest entry is kept
        end else begin
          pend_v_nxt = 1'b1;
          pend_d_nxt = i_data;
        end
      end

      // A new overrun wins over a simultaneous clear.
      if (drop) begin
        ovr_nxt = 1'b1;
      end else if (i_ovr_clr) begin
        ovr_nxt = 1'b0;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      pend_v    <= 1'b0;
      pend_d    <= '0;
      o_level   <= 1'b0;
      o_data    <= '0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      gap_cnt   <= gap_nxt;
      pend_v    <= pend_v_nxt;
      pend_d    <= pend_d_nxt;
      o_data    <= data_nxt;
      o_overrun <= ovr_nxt;
      // Outputs are registered from the next-state view so they line up
      // with the state they describe.
      o_level   <= (state_nxt == HOLD);
      o_busy    <= (state_nxt != IDLE) || pend_v_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch
//
// Drives three pulse_stretch instances with one shared stimulus stream:
//   dut 0: HOLD 16, GAP 1, queued pulses
//   dut 1: HOLD 16, GAP 1, retrigger
//   dut 2: HOLD 3,  GAP 3, queued pulses
// A behavioural model tracks, per instance, how many high and low cycles
// remain plus a one-deep pending slot; every negative clock edge all outputs
// are compared against it. Directed literal checks pin the key timings.
// -----------------------------------------------------------------------------
module tb_pulse_stretch;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_en = 1'b1;
  logic        i_pulse = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_ack = 1'b0;
  logic        i_ovr_clr = 1'b0;

  logic        lvl  [N];
  logic [31:0] dat  [N];
  logic        busy [N];
  logic        ovr  [N];

  int hold_p [N] = '{16, 16, 3};
  int gap_p  [N] = '{1, 1, 3};
  bit rt_p   [N] = '{1'b0, 1'b1, 1'b0};

  // Model state: remaining high cycles, remaining low cycles, pending slot.
  int          m_hi   [N];
  int          m_lo   [N];
  bit          m_pv   [N];
  logic [31:0] m_pd   [N];
  logic [31:0] m_data [N];
  bit          m_ovr  [N];

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pulse_stretch #(.DW(32), .HOLD_CYCLES(16), .GAP_CYCLES(1), .RETRIGGER(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .i_pulse(i_pulse), .i_data(i_data),
    .i_ack(i_ack), .i_ovr_clr(i_ovr_clr), .o_level(lvl[0]), .o_data(dat[0]),
    .o_busy(busy[0]), .o_overrun(ovr[0])
  );

  pulse_stretch #(.DW(32), .HOLD_CYCLES(16), .GAP_CYCLES(1), .RETRIGGER(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .i_pulse(i_pulse), .i_data(i_data),
    .i_ack(i_ack), .i_ovr_clr(i_ovr_clr), .o_level(lvl[1]), .o_data(dat[1]),
    .o_busy(busy[1]), .o_overrun(ovr[1])
  );

  pulse_stretch #(.DW(32), .HOLD_CYCLES(3), .GAP_CYCLES(3), .RETRIGGER(0)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .i_pulse(i_pulse), .i_data(i_data),
    .i_ack(i_ack), .i_ovr_clr(i_ovr_clr), .o_level(lvl[2]), .o_data(dat[2]),
    .o_busy(busy[2]), .o_overrun(ovr[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_hi[k] = 0; m_lo[k] = 0; m_pv[k] = 1'b0; m_pd[k] = '0;
      m_data[k] = '0; m_ovr[k] = 1'b0;
    end
  endtask

  // Places the current pulse in the pending slot; returns 1 if it is lost.
  function automatic bit enqueue(input int k);
    if (m_pv[k]) return 1'b1;
    m_pv[k] = 1'b1;
    m_pd[k] = i_data;
    return 1'b0;
  endfunction

  task automatic model_step(input int k);
    bit lost = 1'b0;
    if (!i_en) begin
      m_hi[k] = 0; m_lo[k] = 0; m_pv[k] = 1'b0;
    end else begin
      if (m_hi[k] > 0) begin
        if (i_ack) begin
          m_hi[k] = 0;
          m_lo[k] = gap_p[k];
          if (i_pulse) lost = enqueue(k);
        end else if (rt_p[k] && i_pulse) begin
          m_hi[k]   = hold_p[k];
          m_data[k] = i_data;
        end else begin
          m_hi[k]--;
          if (m_hi[k] == 0) m_lo[k] = gap_p[k];
          if (i_pulse) lost = enqueue(k);
        end
      end else if (m_lo[k] > 0) begin
        if (i_pulse) lost = enqueue(k);
        m_lo[k]--;
        if (m_lo[k] == 0 && m_pv[k]) begin
          m_data[k] = m_pd[k];
          m_pv[k]   = 1'b0;
          m_hi[k]   = hold_p[k];
        end
      end else if (i_pulse) begin
        m_data[k] = i_data;
        m_hi[k]   = hold_p[k];
      end
      if (lost) m_ovr[k] = 1'b1;
      else if (i_ovr_clr) m_ovr[k] = 1'b0;
    end
  endtask

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("dut%0d level", k), 32'(lvl[k]), 32'(m_hi[k] > 0));
        check($sformatf("dut%0d data", k), dat[k], m_data[k]);
        check($sformatf("dut%0d busy", k), 32'(busy[k]),
              32'((m_hi[k] > 0) || (m_lo[k] > 0) || m_pv[k]));
        check($sformatf("dut%0d overrun", k), 32'(ovr[k]), 32'(m_ovr[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Applies one cycle of inputs, steps the model at the edge, and returns
  // 1 ns after the edge with the pulse-type inputs released.
  task automatic cyc(input logic p, input logic [31:0] d, input logic a = 1'b0,
                     input logic c = 1'b0, input logic e = 1'b1);
    i_pulse = p; i_data = d; i_ack = a; i_ovr_clr = c; i_en = e;
    @(posedge clk);
    for (int k = 0; k < N; k++) model_step(k);
    #1;
    i_pulse = 1'b0; i_ack = 1'b0; i_ovr_clr = 1'b0; i_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset level", 32'(lvl[0]), 32'h0);
    check("reset data", dat[0], 32'h0);
    check("reset busy", 32'(busy[0]), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Single pulse with defaults: 16 high cycles, one low, then idle.
    cyc(1'b1, 32'hA5);
    check("s1 rise", 32'(lvl[0]), 32'h1);
    check("s1 data", dat[0], 32'hA5);
    for (int i = 0; i < 15; i++) begin
      idle(1);
      check("s1 hold", 32'(lvl[0]), 32'h1);
    end
    idle(1);
    check("s1 gap level", 32'(lvl[0]), 32'h0);
    check("s1 gap busy", 32'(busy[0]), 32'h1);
    check("s1 dut2 idle", 32'(busy[2]), 32'h0);
    idle(1);
    check("s1 idle busy", 32'(busy[0]), 32'h0);
    idle(3);

    // Back-to-back pulses: two separate highs, one low cycle between.
    cyc(1'b1, 32'h1);
    cyc(1'b1, 32'h2);
    check("s2 first data", dat[0], 32'h1);
    idle(14);
    check("s2 first hold end", 32'(lvl[0]), 32'h1);
    idle(1);
    check("s2 gap", 32'(lvl[0]), 32'h0);
    idle(1);
    check("s2 second rise", 32'(lvl[0]), 32'h1);
    check("s2 second data", dat[0], 32'h2);
    check("s2 no overrun", 32'(ovr[0]), 32'h0);
    idle(20);

    // Three pulses: third dropped; clear; clear racing a new overrun.
    cyc(1'b1, 32'h11);
    cyc(1'b1, 32'h22);
    cyc(1'b1, 32'h33);
    check("s3 overrun set", 32'(ovr[0]), 32'h1);
    check("s3 retrig no ovr", 32'(ovr[1]), 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("s3 overrun clr", 32'(ovr[0]), 32'h0);
    cyc(1'b1, 32'h44, 1'b0, 1'b1);
    check("s3 set beats clr", 32'(ovr[0]), 32'h1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    idle(40);
    check("s3 queued data kept", dat[0], 32'h22);
    check("s3 drained", 32'(busy[0]), 32'h0);

    // Retrigger: second pulse 7 cycles later extends the level, no gap.
    cyc(1'b1, 32'h5);
    check("s4 rise", 32'(lvl[1]), 32'h1);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("s4 hold a", 32'(lvl[1]), 32'h1);
    end
    cyc(1'b1, 32'h7);
    check("s4 reload data", dat[1], 32'h7);
    for (int i = 0; i < 15; i++) begin
      idle(1);
      check("s4 hold b", 32'(lvl[1]), 32'h1);
    end
    idle(1);
    check("s4 fall", 32'(lvl[1]), 32'h0);
    idle(40);

    // Early ack together with a pulse: one low cycle, then the new data.
    cyc(1'b1, 32'h5A);
    idle(7);
    cyc(1'b1, 32'h3C, 1'b1);
    check("s5 ack low", 32'(lvl[0]), 32'h0);
    check("s5 ack busy", 32'(busy[0]), 32'h1);
    idle(1);
    check("s5 new rise", 32'(lvl[0]), 32'h1);
    check("s5 new data", dat[0], 32'h3C);
    idle(40);

    // Enable dropped with pending valid: everything idles, data kept.
    cyc(1'b1, 32'h10);
    cyc(1'b1, 32'h20);
    idle(3);
    cyc(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    check("s6 en level", 32'(lvl[0]), 32'h0);
    check("s6 en busy", 32'(busy[0]), 32'h0);
    check("s6 en data", dat[0], 32'h10);
    idle(5);
    check("s6 pending gone", 32'(busy[0]), 32'h0);
    check("s6 still low", 32'(lvl[0]), 32'h0);

    // Asynchronous reset in the middle of GAP with overrun set.
    cyc(1'b1, 32'h99);
    cyc(1'b1, 32'h98);
    cyc(1'b1, 32'h97);
    idle(14);
    check("s7 in gap", 32'(lvl[0]), 32'h0);
    check("s7 gap busy", 32'(busy[0]), 32'h1);
    check("s7 overrun", 32'(ovr[0]), 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("s7 rst level", 32'(lvl[0]), 32'h0);
    check("s7 rst data", dat[0], 32'h0);
    check("s7 rst busy", 32'(busy[0]), 32'h0);
    check("s7 rst overrun", 32'(ovr[0]), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    check("s7 after reset", 32'(busy[0]), 32'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
